// File: rtl/sram_fifo_arbiter.sv
// sram_fifo_arbiter: NUM_CH circular FIFOs sharing one async SRAM, round-robin served.
// Optional macro SRAM_FIFO_FLUSH_EN adds a per-channel flush input.
module sram_fifo_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int CH_AW     = 17,
  parameter int DW        = 16,
  parameter int AF_MARGIN = 128,
  localparam int AW = CH_AW + $clog2(NUM_CH),
  localparam int CW = CH_AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef SRAM_FIFO_FLUSH_EN
  input  logic [NUM_CH-1:0]    flush,
`endif
  input  logic [NUM_CH-1:0]    wr_req,
  input  logic [NUM_CH*DW-1:0] wr_data,
  output logic [NUM_CH-1:0]    wr_ack,
  input  logic [NUM_CH-1:0]    rd_req,
  output logic [NUM_CH-1:0]    rd_ack,
  output logic [DW-1:0]        rd_data,
  output logic [NUM_CH-1:0]    fifo_empty,
  output logic [NUM_CH-1:0]    fifo_full,
  output logic [NUM_CH-1:0]    fifo_afull,
  output logic [NUM_CH*CW-1:0] fifo_count,
  output logic [AW-1:0]        mem_addr,
  inout  wire  [DW-1:0]        Dout,
  output logic                 CE_n,
  output logic                 OE_n,
  output logic                 WE_n,
  output logic                 LB_n,
  output logic                 UB_n
);

  localparam int DEPTH = 1 << CH_AW;
  localparam int NS    = 2 * NUM_CH;
  localparam int SW    = $clog2(NS);
  localparam int CHW   = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    rr, gnt, idx;
  logic             found;
  logic [NS-1:0]    elig;
  logic [CHW-1:0]   gnt_ch, cur_ch;
  logic             cur_wr;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             drive;
  logic [CH_AW-1:0] wptr [NUM_CH];
  logic [CH_AW-1:0] rptr [NUM_CH];
  logic [CH_AW-1:0] wptr_nxt [NUM_CH];
  logic [CH_AW-1:0] rptr_nxt [NUM_CH];
  logic [CW-1:0]    cnt [NUM_CH];
  logic [CW-1:0]    cnt_nxt [NUM_CH];

  assign gnt_ch   = gnt[SW-1:1];
  assign mem_addr = addr_q;
  assign Dout     = drive ? wdata_q : {DW{1'bz}};

  // Slot eligibility and first eligible slot at or after the RR pointer
  always_comb begin
    elig  = '0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[2*c]   = wr_req[c] & ~fifo_full[c];
      elig[2*c+1] = rd_req[c] & ~fifo_empty[c];
    end
    for (int k = 0; k < NS; k++) begin
      idx = rr + SW'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: fixed 4-cycle SRAM access
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: SRAM strobes, bus drive, ack pulses
  always_comb begin
    CE_n   = 1'b1;
    OE_n   = 1'b1;
    WE_n   = 1'b1;
    LB_n   = 1'b1;
    UB_n   = 1'b1;
    drive  = 1'b0;
    wr_ack = '0;
    rd_ack = '0;
    unique case (state)
      SETUP: begin
        CE_n  = 1'b0;
        LB_n  = 1'b0;
        UB_n  = 1'b0;
        OE_n  = cur_wr;
        drive = cur_wr;
      end
      STROBE: begin
        CE_n  = 1'b0;
        LB_n  = 1'b0;
        UB_n  = 1'b0;
        OE_n  = cur_wr;
        WE_n  = ~cur_wr;
        drive = cur_wr;
      end
      DONE: begin
        if (cur_wr) wr_ack[cur_ch] = 1'b1;
        else        rd_ack[cur_ch] = 1'b1;
      end
      default: ;
    endcase
  end

  // Latch the granted operation and capture read data
  always_ff @(posedge clk) begin
    if (reset) begin
      rr      <= '0;
      cur_ch  <= '0;
      cur_wr  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_data <= '0;
    end else begin
      if (state == IDLE && found) begin
        rr      <= gnt + SW'(1);
        cur_ch  <= gnt_ch;
        cur_wr  <= ~gnt[0];
        addr_q  <= {gnt_ch, gnt[0] ? rptr[gnt_ch] : wptr[gnt_ch]};
        wdata_q <= wr_data[gnt_ch*DW +: DW];
      end
      if (state == STROBE && !cur_wr) rd_data <= Dout;
    end
  end

  // Pointer/count update at the end of DONE; flush overrides it
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wptr_nxt[c] = wptr[c];
      rptr_nxt[c] = rptr[c];
      cnt_nxt[c]  = cnt[c];
      if (state == DONE && cur_ch == CHW'(c)) begin
        if (cur_wr) begin
          wptr_nxt[c] = wptr[c] + CH_AW'(1);
          cnt_nxt[c]  = cnt[c] + CW'(1);
        end else begin
          rptr_nxt[c] = rptr[c] + CH_AW'(1);
          cnt_nxt[c]  = cnt[c] - CW'(1);
        end
      end
`ifdef SRAM_FIFO_FLUSH_EN
      if (flush[c]) begin
        wptr_nxt[c] = '0;
        rptr_nxt[c] = '0;
        cnt_nxt[c]  = '0;
      end
`endif
    end
  end

  // Pointer, count and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
      fifo_empty <= '1;
      fifo_full  <= '0;
      fifo_afull <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c]       <= wptr_nxt[c];
        rptr[c]       <= rptr_nxt[c];
        cnt[c]        <= cnt_nxt[c];
        fifo_empty[c] <= (cnt_nxt[c] == '0);
        fifo_full[c]  <= (cnt_nxt[c] == CW'(DEPTH));
        fifo_afull[c] <= (int'(cnt_nxt[c]) > DEPTH - AF_MARGIN);
      end
    end
  end

  // Flatten per-channel counts
  always_comb begin
    fifo_count = '0;
    for (int c = 0; c < NUM_CH; c++) fifo_count[c*CW +: CW] = cnt[c];
  end

endmodule
